// File: rtl/stick_pkg.sv
// Shared definitions for the stick transmit path: arbiter state encoding and
// the width of the Avalon-ST empty-byte field.
package stick_pkg;

    localparam int MOD_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/frm_rr_pick.sv
// Two-way round-robin pick: when both sources request, the one that did not
// win last time is chosen; a single requester always wins.
module frm_rr_pick (
    input  logic [1:0] cand_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       grant_vld_o
);

    always_comb begin
        grant_vld_o = |cand_i;
        if (&cand_i) begin
            grant_o = ~last_i;
        end else begin
            grant_o = cand_i[1];
        end
    end

endmodule

// File: rtl/tx_frame_arb.sv
// Whole-frame round-robin arbiter sharing the MAC transmit FIFO between the
// measurement source (0) and the command-reply source (1), with stall abort.
module tx_frame_arb
    import stick_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [DW-1:0]    i_s0_data,
    input  logic             i_s0_vld,
    input  logic             i_s0_sop,
    input  logic             i_s0_eop,
    input  logic [MOD_W-1:0] i_s0_mod,
    output logic             o_s0_rdy,

    input  logic [DW-1:0]    i_s1_data,
    input  logic             i_s1_vld,
    input  logic             i_s1_sop,
    input  logic             i_s1_eop,
    input  logic [MOD_W-1:0] i_s1_mod,
    output logic             o_s1_rdy,

    output logic [DW-1:0]    o_tx_data,
    output logic             o_tx_vld,
    output logic             o_tx_sop,
    output logic             o_tx_eop,
    output logic [MOD_W-1:0] o_tx_mod,
    output logic             o_tx_err,
    input  logic             i_tx_rdy,

    output logic             o_busy,
    output logic [CNT_W-1:0] o_frm_cnt0,
    output logic [CNT_W-1:0] o_frm_cnt1,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  frm0_q, frm0_d;
    logic [CNT_W-1:0]  frm1_q, frm1_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              pick;
    logic              pick_vld;
    logic              drain0;
    logic              drain1;
    logic              xfer;

    logic [DW-1:0]     g_data;
    logic              g_vld;
    logic              g_sop;
    logic              g_eop;
    logic [MOD_W-1:0]  g_mod;

    frm_rr_pick u_pick (
        .cand_i      ({i_s1_vld & i_s1_sop, i_s0_vld & i_s0_sop}),
        .last_i      (last_q),
        .grant_o     (pick),
        .grant_vld_o (pick_vld)
    );

    assign g_data = grant_q ? i_s1_data : i_s0_data;
    assign g_vld  = grant_q ? i_s1_vld  : i_s0_vld;
    assign g_sop  = grant_q ? i_s1_sop  : i_s0_sop;
    assign g_eop  = grant_q ? i_s1_eop  : i_s0_eop;
    assign g_mod  = grant_q ? i_s1_mod  : i_s0_mod;

    assign o_busy     = (state_q != ST_IDLE);
    assign o_frm_cnt0 = frm0_q;
    assign o_frm_cnt1 = frm1_q;
    assign o_drop_cnt = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            idle_q  <= '0;
            frm0_q  <= '0;
            frm1_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
            frm0_q  <= frm0_d;
            frm1_q  <= frm1_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        idle_d    = idle_q;
        frm0_d    = frm0_q;
        frm1_d    = frm1_q;
        drop_d    = drop_q;
        o_s0_rdy  = 1'b0;
        o_s1_rdy  = 1'b0;
        o_tx_data = '0;
        o_tx_vld  = 1'b0;
        o_tx_sop  = 1'b0;
        o_tx_eop  = 1'b0;
        o_tx_mod  = '0;
        o_tx_err  = 1'b0;
        drain0    = 1'b0;
        drain1    = 1'b0;
        xfer      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = ST_BUSY;
                end
                // Orphan beats (leftovers of an aborted frame) are swallowed here.
                drain0   = i_s0_vld & ~i_s0_sop & ~(pick_vld & ~pick);
                drain1   = i_s1_vld & ~i_s1_sop & ~(pick_vld &  pick);
                o_s0_rdy = drain0;
                o_s1_rdy = drain1;
                drop_d   = drop_q + CNT_W'(drain0) + CNT_W'(drain1);
            end

            ST_BUSY: begin
                o_tx_data = g_data;
                o_tx_vld  = g_vld;
                o_tx_sop  = g_sop;
                o_tx_eop  = g_eop;
                o_tx_mod  = g_mod;
                o_s0_rdy  = i_tx_rdy & ~grant_q;
                o_s1_rdy  = i_tx_rdy &  grant_q;
                xfer      = g_vld & i_tx_rdy;
                if (xfer) begin
                    idle_d = '0;
                    if (g_eop) begin
                        if (grant_q) begin
                            frm1_d = frm1_q + 1'b1;
                        end else begin
                            frm0_d = frm0_q + 1'b1;
                        end
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    idle_d  = '0;
                    state_d = ST_ABORT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            ST_ABORT: begin
                o_tx_vld = 1'b1;
                o_tx_eop = 1'b1;
                o_tx_err = 1'b1;
                if (i_tx_rdy) begin
                    drop_d  = drop_q + 1'b1;
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_frame_arb.sv
// Scoreboard bench for tx_frame_arb: expected MAC beats are queued as frames are
// driven and compared as the arbiter emits them.
module tb_tx_frame_arb;

    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    typedef logic [36:0] beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DW-1:0]    i_s0_data = '0;
    logic             i_s0_vld = 1'b0;
    logic             i_s0_sop = 1'b0;
    logic             i_s0_eop = 1'b0;
    logic [1:0]       i_s0_mod = '0;
    logic             o_s0_rdy;
    logic [DW-1:0]    i_s1_data = '0;
    logic             i_s1_vld = 1'b0;
    logic             i_s1_sop = 1'b0;
    logic             i_s1_eop = 1'b0;
    logic [1:0]       i_s1_mod = '0;
    logic             o_s1_rdy;
    logic [DW-1:0]    o_tx_data;
    logic             o_tx_vld;
    logic             o_tx_sop;
    logic             o_tx_eop;
    logic [1:0]       o_tx_mod;
    logic             o_tx_err;
    logic             i_tx_rdy = 1'b1;
    logic             o_busy;
    logic [CNT_W-1:0] o_frm_cnt0;
    logic [CNT_W-1:0] o_frm_cnt1;
    logic [CNT_W-1:0] o_drop_cnt;

    beat_t sbQ[$];
    int    passCnt = 0;
    int    checkCnt = 0;
    int    cycleCnt = 0;
    int    presentCycle = 0;
    int    lastEopCycle = -1;
    int    expFrm0 = 0;
    int    expFrm1 = 0;
    int    expDrop = 0;
    bit    latChk = 0;
    bit    gapChk = 0;
    bit    mirrorChk = 0;
    bit    s1RdyZero = 0;

    tx_frame_arb #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s0_data  (i_s0_data),
        .i_s0_vld   (i_s0_vld),
        .i_s0_sop   (i_s0_sop),
        .i_s0_eop   (i_s0_eop),
        .i_s0_mod   (i_s0_mod),
        .o_s0_rdy   (o_s0_rdy),
        .i_s1_data  (i_s1_data),
        .i_s1_vld   (i_s1_vld),
        .i_s1_sop   (i_s1_sop),
        .i_s1_eop   (i_s1_eop),
        .i_s1_mod   (i_s1_mod),
        .o_s1_rdy   (o_s1_rdy),
        .o_tx_data  (o_tx_data),
        .o_tx_vld   (o_tx_vld),
        .o_tx_sop   (o_tx_sop),
        .o_tx_eop   (o_tx_eop),
        .o_tx_mod   (o_tx_mod),
        .o_tx_err   (o_tx_err),
        .i_tx_rdy   (i_tx_rdy),
        .o_busy     (o_busy),
        .o_frm_cnt0 (o_frm_cnt0),
        .o_frm_cnt1 (o_frm_cnt1),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mkBeat(input logic err, input logic sop, input logic eop,
                                     input logic [1:0] mod, input logic [31:0] data);
        return {err, sop, eop, mod, data};
    endfunction

    function automatic logic [31:0] frameData(input int src, input int frm, input int b);
        return 32'hA000_0000 | (32'(src) << 16) | (32'(frm) << 8) | 32'(b);
    endfunction

    task automatic pushFrame(input int src, input int frm, input int nBeats);
        for (int b = 0; b < nBeats; b++) begin
            sbQ.push_back(mkBeat(1'b0, b == 0, b == nBeats - 1, 2'(b), frameData(src, frm, b)));
        end
    endtask

    task automatic driveBeat(input int src, input logic vld, input logic sop, input logic eop,
                             input logic [1:0] mod, input logic [31:0] data);
        if (src == 0) begin
            i_s0_vld = vld; i_s0_sop = sop; i_s0_eop = eop; i_s0_mod = mod; i_s0_data = data;
        end else begin
            i_s1_vld = vld; i_s1_sop = sop; i_s1_eop = eop; i_s1_mod = mod; i_s1_data = data;
        end
    endtask

    // Returns #1 after the clock edge at which the current beat was taken.
    task automatic waitAccept(input int src, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rst_n && ((src == 0) ? o_s0_rdy : o_s1_rdy)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("acceptTimeout", ok, 1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int src, input int frm, input int nBeats,
                                 input int nSend, input bit push);
        bit ok;
        ok = 1;
        for (int b = 0; b < nSend; b++) begin
            driveBeat(src, 1'b1, b == 0, b == nBeats - 1, 2'(b), frameData(src, frm, b));
            if (b == 0) presentCycle = cycleCnt;
            if (push) sbQ.push_back(mkBeat(1'b0, b == 0, b == nBeats - 1, 2'(b), frameData(src, frm, b)));
            waitAccept(src, ok);
            if (!ok) break;
        end
        driveBeat(src, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        if (ok && nSend == nBeats) begin
            if (src == 0) expFrm0++;
            else expFrm1++;
        end
    endtask

    task automatic resetDut();
        #1;
        rst_n = 1'b0;
        driveBeat(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        driveBeat(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        i_tx_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expFrm0 = 0; expFrm1 = 0; expDrop = 0;
        lastEopCycle = -1;
    endtask

    always @(negedge clk) begin : monitor
        beat_t obs;
        beat_t exp;
        if (rst_n) begin
            if (o_tx_vld && i_tx_rdy) begin
                obs = {o_tx_err, o_tx_sop, o_tx_eop, o_tx_mod, o_tx_data};
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedBeat", sbQ.size(), 1);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("beat", obs, exp);
                end
                if (o_tx_sop && latChk) checkOutput("latency", cycleCnt - presentCycle, 1);
                if (o_tx_sop && gapChk && lastEopCycle >= 0) checkOutput("bubble", cycleCnt - lastEopCycle, 2);
                if (o_tx_eop) lastEopCycle = cycleCnt;
            end
            if (mirrorChk && o_busy) checkOutput("rdyMirror", o_s0_rdy, i_tx_rdy);
            if (s1RdyZero) checkOutput("s1RdyIdle", o_s1_rdy, 0);
        end
    end

    initial begin
        bit ok;
        bit toggleDone;
        int busyCyc;

        // Reset values while rst_n is held low.
        #2;
        checkOutput("rstBusy0", o_busy, 0);
        checkOutput("rstTxVld0", o_tx_vld, 0);
        checkOutput("rstRdy0", {o_s0_rdy, o_s1_rdy}, 0);
        checkOutput("rstCnt0", {o_frm_cnt0, o_frm_cnt1, o_drop_cnt}, 0);
        @(posedge clk);
        resetDut();

        // Single 4-beat frame from source 0.
        latChk = 1; s1RdyZero = 1;
        applyStimulus(0, 0, 4, 4, 1);
        latChk = 0; s1RdyZero = 0;
        @(negedge clk);
        checkOutput("t1Frm0", o_frm_cnt0, expFrm0);
        checkOutput("t1Busy", o_busy, 0);

        // Both sources contend for three frames each.
        @(posedge clk);
        resetDut();
        for (int f = 0; f < 3; f++) begin
            pushFrame(0, f, 3);
            pushFrame(1, f, 2);
        end
        gapChk = 1;
        fork
            begin
                for (int f = 0; f < 3; f++) applyStimulus(0, f, 3, 3, 0);
            end
            begin
                for (int f = 0; f < 3; f++) applyStimulus(1, f, 2, 2, 0);
            end
        join
        gapChk = 0;
        @(negedge clk);
        checkOutput("t2Frm0", o_frm_cnt0, expFrm0);
        checkOutput("t2Frm1", o_frm_cnt1, expFrm1);
        checkOutput("t2Order", sbQ.size(), 0);

        // Downstream ready toggling during a 6-beat frame.
        @(posedge clk);
        #1;
        toggleDone = 0;
        mirrorChk = 1;
        fork
            begin
                applyStimulus(0, 7, 6, 6, 1);
                toggleDone = 1;
            end
            begin
                while (!toggleDone) begin
                    @(posedge clk);
                    #1;
                    i_tx_rdy = ~i_tx_rdy;
                end
            end
        join
        mirrorChk = 0;
        i_tx_rdy = 1'b1;
        @(negedge clk);
        checkOutput("t3Frm0", o_frm_cnt0, expFrm0);

        // Source 1 stalls mid-frame and is aborted, then its leftovers drained.
        @(posedge clk);
        #1;
        applyStimulus(1, 3, 4, 2, 1);
        sbQ.push_back(mkBeat(1'b1, 1'b0, 1'b1, 2'd0, 32'd0));
        expDrop++;
        busyCyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_busy) busyCyc++;
            else break;
        end
        checkOutput("timeoutLen", busyCyc, TIMEOUT + 1);
        checkOutput("dropAbort", o_drop_cnt, expDrop);
        @(posedge clk);
        #1;
        for (int b = 2; b < 4; b++) begin
            driveBeat(1, 1'b1, 1'b0, b == 3, 2'(b), frameData(1, 3, b));
            waitAccept(1, ok);
            if (ok) expDrop++;
        end
        driveBeat(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        checkOutput("dropTrail", o_drop_cnt, expDrop);
        checkOutput("t4Frm1", o_frm_cnt1, expFrm1);

        // Source 0 beats without sop while idle are discarded.
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            driveBeat(0, 1'b1, 1'b0, 1'b0, 2'(b), 32'h5555_0000 | 32'(b));
            waitAccept(0, ok);
            if (ok) expDrop++;
        end
        driveBeat(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        checkOutput("dropOrphan", o_drop_cnt, expDrop);
        checkOutput("t5Frm0", o_frm_cnt0, expFrm0);

        // Asynchronous reset in the middle of a 5-beat frame.
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            driveBeat(0, 1'b1, b == 0, 1'b0, 2'(b), frameData(0, 9, b));
            sbQ.push_back(mkBeat(1'b0, b == 0, 1'b0, 2'(b), frameData(0, 9, b)));
            waitAccept(0, ok);
        end
        driveBeat(0, 1'b1, 1'b0, 1'b0, 2'd2, frameData(0, 9, 2));
        #2;
        rst_n = 1'b0;
        driveBeat(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        #1;
        checkOutput("midRstBusy", o_busy, 0);
        checkOutput("midRstTx", {o_tx_vld, o_tx_sop, o_tx_eop, o_tx_err, o_tx_mod, o_tx_data}, 0);
        checkOutput("midRstRdy", {o_s0_rdy, o_s1_rdy}, 0);
        checkOutput("midRstCnt", {o_frm_cnt0, o_frm_cnt1, o_drop_cnt}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expFrm0 = 0; expFrm1 = 0; expDrop = 0;
        latChk = 1;
        applyStimulus(0, 10, 3, 3, 1);
        latChk = 0;
        @(negedge clk);
        checkOutput("postRstFrm0", o_frm_cnt0, expFrm0);
        checkOutput("postRstDrop", o_drop_cnt, expDrop);

        repeat (3) @(negedge clk);
        checkOutput("sbEmpty", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tx_frame_arb.md
Name: tx_frame_arb

Overview:
- Shares the single MAC transmit FIFO interface (32-bit Avalon-ST: data/vld/sop/eop/mod/rdy) between two frame sources.
  - Source 0: measurement data frames from stick_main.
  - Source 1: command-reply/status frames.
- Arbitrates whole frames round-robin and never interleaves beats of two frames.
- Aborts a stalled frame with an error-terminated beat so the MAC is never left holding a half frame.
- Sits between the frame producers and the MAC ff_tx_* port, in the sys_clk domain.

Parameters:
- DW, 32, data width of all data buses.
- TIMEOUT, 4096, cycles without an accepted beat while granted before the frame is aborted (>=2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock (sys_clk)
- rst_n  in  1  asynchronous active-low reset
- i_s0_data  in  DW  source 0 beat data
- i_s0_vld  in  1  source 0 beat valid
- i_s0_sop  in  1  source 0 start of frame
- i_s0_eop  in  1  source 0 end of frame
- i_s0_mod  in  2  source 0 empty-byte count on eop beat
- o_s0_rdy  out  1  source 0 beat accepted when vld&rdy
- i_s1_data, i_s1_vld, i_s1_sop, i_s1_eop, i_s1_mod, o_s1_rdy: same as s0, for source 1
- o_tx_data  out  DW  to MAC ff_tx_data
- o_tx_vld  out  1  to MAC ff_tx_wren
- o_tx_sop  out  1  to MAC ff_tx_sop
- o_tx_eop  out  1  to MAC ff_tx_eop
- o_tx_mod  out  2  to MAC ff_tx_mod
- o_tx_err  out  1  to MAC ff_tx_err, set only on the abort beat
- i_tx_rdy  in  1  from MAC ff_tx_rdy
- o_busy  out  1  a frame is granted or being aborted
- o_frm_cnt0  out  CNT_W  frames from source 0 completed with eop
- o_frm_cnt1  out  CNT_W  frames from source 1 completed with eop
- o_drop_cnt  out  CNT_W  beats discarded plus frames aborted

Behaviour:
- Reset state:
  - State IDLE, grant=0, last=1 (source 0 wins first).
  - All tx outputs 0, both rdy 0, counters 0, o_busy 0.
- Beat transfer: upstream vld&rdy on the granted source; downstream o_tx_vld&i_tx_rdy.
- State IDLE:
  - Sources with vld&sop are candidates.
  - Both candidates: grant the one not equal to last. One candidate: grant it.
  - Register grant; next cycle -> BUSY. Arbitration latency is 1 cycle; the first beat passes in the BUSY cycle.
  - A source with vld and no sop in IDLE is drained: its rdy=1 that cycle, beat discarded, o_drop_cnt+1.
  - A source that is granted that cycle is never drained.
- State BUSY:
  - Combinational pass-through: o_tx_* = granted source fields; o_tx_vld = granted vld.
  - o_sN_rdy = i_tx_rdy & (grant==N). The other source's rdy=0.
  - o_tx_err=0.
  - Idle counter resets on each transfer, increments otherwise.
  - Transfer with eop: frame counter of grant +1, last<=grant, -> IDLE. The next grant is earliest the following cycle, so there is a 1-cycle bubble between frames.
  - sop seen mid-frame is passed through unchanged; the MAC handles it.
  - Idle counter reaching TIMEOUT-1 -> ABORT.
- State ABORT:
  - Drive o_tx_vld=1, sop=0, eop=1, err=1, data=0, mod=0. Both source rdy=0.
  - On i_tx_rdy: o_drop_cnt+1, last<=grant, -> IDLE.
  - The remaining beats of the aborted frame are later drained in IDLE and counted.
- Counters wrap at 2^CNT_W-1 -> 0.
- Simultaneous drains of both sources in one IDLE cycle add 2 to o_drop_cnt.
- o_busy = state != IDLE.
- Reset asserted mid-frame returns everything to reset values immediately. No abort beat is emitted; the MAC is reset from the same rst_n.

Decomposition:
- Shared package (stick_pkg): state encoding constants ST_IDLE/ST_BUSY/ST_ABORT, MOD_W=2.
- One natural sub-module: frm_rr_pick. It is combinational 2-way round-robin selection from the candidate vector and last, giving a grant index and grant-valid. Everything else stays in tx_frame_arb.

Test Plan:
- Source 0 sends a 4-beat frame, i_tx_rdy=1 -> o_tx_* shows the 4 beats starting 1 cycle after vld&sop; o_frm_cnt0=1; o_s1_rdy stays 0.
- Both sources present sop in the same cycle, three frames each -> output order s0,s1,s0,s1,s0,s1; no beat interleaving; 1 idle cycle between frames; both frame counters 3.
- i_tx_rdy toggles 1/0 every cycle during a 6-beat frame -> all 6 beats delivered in order with no duplicates; granted rdy mirrors i_tx_rdy.
- Source 1 holds vld=0 for TIMEOUT cycles mid-frame (TIMEOUT=16) -> one beat with eop=1, err=1, data=0; then IDLE; o_drop_cnt=1. Two trailing non-sop beats are drained -> o_drop_cnt=3.
- Source 0 presents 2 beats without sop in IDLE -> both drained (rdy=1), nothing on o_tx_vld, o_drop_cnt=2.
- rst_n pulsed low while BUSY on beat 2 of 5 -> all outputs 0 asynchronously; after release, a new sop frame from source 0 is granted normally.
